column_alu: RTL and testbench
=============================

Name: column_alu

Overview:
- Parametrised successor to the single-op arithmetic dut.
- Streaming signed element-wise ALU for column operations: ADD, SUB, MUL, MIN, MAX, EQ, GT, plus a SUM reduction over a column.
- Fixed 2-stage pipeline with valid/ready handshakes on input and output, and full backpressure.
- Sits between the column DMA reader and the result writer in the pandas offload path.

Parameters:
- WIDTH, 32, signed operand/result width in bits (≥4).
- CMD_W, 4, opcode width in bits.
- ACC_W, WIDTH+16, internal SUM accumulator width in bits (≥WIDTH).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  accept enable; low blocks new input only
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in1  in  WIDTH  signed operand A
- in2  in  WIDTH  signed operand B
- cmd  in  CMD_W  opcode
- in_last  in  1  last element of a column (SUM only)
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out  out  WIDTH  signed result
- out_ovf  out  1  overflow occurred for this result
- out_err  out  1  illegal opcode for this result

Behaviour:
- Reset (async, active-high) sets:
  - out_valid, out, out_ovf, out_err, and both stage-valid bits to 0.
  - accumulator to 0 and the sum_active flag to 0.
- Opcodes:
  - 0 NOOP: out=in1.
  - 1 ADD: in1+in2.
  - 2 SUB: in1-in2.
  - 3 MUL: low WIDTH bits of the signed 2·WIDTH product.
  - 4 MIN, 5 MAX: signed comparison.
  - 6 EQ, 7 GT: result 1/0, zero-extended.
  - 8 SUM: reduction, described below.
  - 9..2^CMD_W-1: out=0, out_err=1, out_ovf=0.
- Pipeline advance:
  - adv = out_ready || !out_valid.
  - in_ready = enable && adv (combinational).
  - On a stall, both stages hold their contents unchanged.
- Latency: an element-wise beat accepted at edge N appears with out_valid=1 after edge N+2, given no stall.
- Throughput: one beat per cycle.
- Stage 1 registers operands and opcode, and computes the full-precision result.
- Stage 2 applies wrap or saturation, registers out/out_ovf/out_err, and updates the accumulator.
- Overflow flag, out_ovf:
  - ADD/SUB/SUM: set on signed overflow of the WIDTH-bit result.
  - MUL: set when the product does not fit in WIDTH signed bits.
  - All other ops: 0.
- SUM reduction:
  - Each accepted SUM beat adds sign-extended in1 to the ACC_W accumulator; in2 is ignored.
  - A non-last beat sets sum_active=1 and produces no output beat.
  - An in_last beat emits the WIDTH-bit result of acc+in1, with out_ovf=1 if the value exceeds the WIDTH signed range. It then clears acc to 0 and sum_active to 0.
  - A single beat with in_last=1 and no prior SUM beats emits in1.
  - ACC_W internal overflow wraps silently.
- Element-wise beats interleaved inside an open SUM are processed normally; the accumulator is untouched.
- in_last on a non-SUM opcode is ignored.
- enable deasserted mid-stream: no new beats are accepted. In-flight beats still drain, and the accumulator is preserved.
- Once out_valid=1, out/out_ovf/out_err stay stable until out_ready.
- Reset mid-operation discards in-flight beats and any partial SUM immediately, independent of clk.

Optional Feature:
- Macro: COLUMN_ALU_SAT_EN.
- Defined: on overflow, ADD/SUB/MUL/SUM results clamp to +2^(WIDTH-1)-1 or -2^(WIDTH-1) according to the sign of the true result. out_ovf is still asserted.
- Undefined: results wrap as two's complement, with out_ovf asserted. Saturation logic is absent from the netlist.

Test Plan (WIDTH=8):
1. ADD in1=100,in2=27, out_ready=1 -> after 2 cycles out=127,out_ovf=0. Then in1=100,in2=28 -> out=-128,ovf=1 without SAT_EN; out=127,ovf=1 with SAT_EN.
2. Back-to-back SUB 5-9, MUL -8*16, MIN(-3,4), GT(7,7) -> consecutive cycles give:
   - -4, ovf=0.
   - -128, ovf=0.
   - -3.
   - 0.
3. SUM beats 50,50,50(last) -> exactly one output beat. out=150-256=-106 with ovf=1; 127 with SAT_EN. The next SUM of 3(last) -> out=3.
4. Hold out_ready=0 for 5 cycles during a stream of ADD beats -> in_ready drops once both stages are full. No beat is lost or duplicated, and the order is preserved after release.
5. cmd=12 -> out=0,out_err=1. enable=0 while 2 beats are in flight -> both beats drain, then in_ready stays 0.
6. Assert reset asynchronously mid-SUM (acc=40) -> out_valid=0 immediately. After release, SUM 1(last) -> out=1.

Source files
------------

// File: rtl/column_alu.sv
// column_alu: signed element-wise ALU with a SUM column reduction. COLUMN_ALU_SAT_EN selects clamping instead of wrapping.
// Latency: a beat accepted at edge N is presented after edge N+2. Throughput is one beat per cycle.
// Backpressure: the whole pipeline holds while out_valid && !out_ready. in_ready = enable && advance.
module column_alu #(
  parameter int WIDTH = 32,
  parameter int CMD_W = 4,
  parameter int ACC_W = WIDTH + 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [CMD_W-1:0] cmd,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_ovf,
  output logic             out_err
);
  localparam int FW = 2 * WIDTH;
  localparam logic [CMD_W-1:0] OP_NOOP = CMD_W'(0);
  localparam logic [CMD_W-1:0] OP_ADD  = CMD_W'(1);
  localparam logic [CMD_W-1:0] OP_SUB  = CMD_W'(2);
  localparam logic [CMD_W-1:0] OP_MUL  = CMD_W'(3);
  localparam logic [CMD_W-1:0] OP_MIN  = CMD_W'(4);
  localparam logic [CMD_W-1:0] OP_MAX  = CMD_W'(5);
  localparam logic [CMD_W-1:0] OP_EQ   = CMD_W'(6);
  localparam logic [CMD_W-1:0] OP_GT   = CMD_W'(7);
  localparam logic [CMD_W-1:0] OP_SUM  = CMD_W'(8);

  logic w_adv, w_take;
  assign w_adv    = out_ready || !out_valid;
  assign in_ready = enable && w_adv;
  assign w_take   = in_valid && in_ready;

  logic                    r_s1_vld, r_s1_last;
  logic [CMD_W-1:0]        r_s1_cmd;
  logic signed [WIDTH-1:0] r_s1_a, r_s1_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_cmd  <= '0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
    end else if (w_adv) begin
      r_s1_vld <= w_take;
      if (w_take) begin
        r_s1_cmd  <= cmd;
        r_s1_a    <= in1;
        r_s1_b    <= in2;
        r_s1_last <= in_last;
      end
    end
  end

  // Full-precision result at 2*WIDTH: every legal op fits without loss.
  logic signed [FW-1:0] w_a_x, w_b_x, w_full;
  assign w_a_x = FW'(r_s1_a);
  assign w_b_x = FW'(r_s1_b);

  always_comb begin
    w_full = '0;
    case (r_s1_cmd)
      OP_NOOP, OP_SUM: w_full = w_a_x;
      OP_ADD:          w_full = w_a_x + w_b_x;
      OP_SUB:          w_full = w_a_x - w_b_x;
      OP_MUL:          w_full = w_a_x * w_b_x;
      OP_MIN:          w_full = (w_a_x < w_b_x) ? w_a_x : w_b_x;
      OP_MAX:          w_full = (w_a_x > w_b_x) ? w_a_x : w_b_x;
      OP_EQ:           w_full = FW'(w_a_x == w_b_x);
      OP_GT:           w_full = FW'(w_a_x > w_b_x);
      default:         w_full = '0;
    endcase
  end

  logic                 r_s2_vld, r_s2_last;
  logic [CMD_W-1:0]     r_s2_cmd;
  logic signed [FW-1:0] r_s2_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_vld  <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_cmd  <= '0;
      r_s2_full <= '0;
    end else if (w_adv) begin
      r_s2_vld  <= r_s1_vld;
      r_s2_cmd  <= r_s1_cmd;
      r_s2_last <= r_s1_last;
      r_s2_full <= w_full;
    end
  end

  logic                    r_sum_active;
  logic signed [ACC_W-1:0] r_acc;
  logic                    w_is_sum, w_is_arith, w_s2_err, w_emit;
  logic                    w_full_fit, w_sum_fit, w_ovf;
  logic signed [WIDTH-1:0] w_s2_lo, w_res;
  logic signed [ACC_W-1:0] w_acc_base, w_acc_sum;
  logic [FW-WIDTH:0]       w_full_hi;
  logic [ACC_W-WIDTH:0]    w_sum_hi;

  assign w_is_sum   = (r_s2_cmd == OP_SUM);
  assign w_is_arith = (r_s2_cmd == OP_ADD) || (r_s2_cmd == OP_SUB) || (r_s2_cmd == OP_MUL);
  assign w_s2_err   = (r_s2_cmd > OP_SUM);
  assign w_emit     = r_s2_vld && !(w_is_sum && !r_s2_last);
  assign w_s2_lo    = r_s2_full[WIDTH-1:0];
  assign w_acc_base = r_sum_active ? r_acc : '0;
  assign w_acc_sum  = w_acc_base + ACC_W'(w_s2_lo);
  // A value fits WIDTH signed bits when everything above the sign bit copies it.
  assign w_full_hi  = r_s2_full[FW-1:WIDTH-1];
  assign w_sum_hi   = w_acc_sum[ACC_W-1:WIDTH-1];
  assign w_full_fit = (&w_full_hi) || !(|w_full_hi);
  assign w_sum_fit  = (&w_sum_hi) || !(|w_sum_hi);

`ifdef COLUMN_ALU_SAT_EN
  logic w_neg;
  assign w_neg = w_is_sum ? w_acc_sum[ACC_W-1] : r_s2_full[FW-1];
`endif

  always_comb begin
    w_res = w_s2_lo;
    w_ovf = 1'b0;
    if (w_is_sum) begin
      w_res = w_acc_sum[WIDTH-1:0];
      w_ovf = !w_sum_fit;
    end else if (w_is_arith) begin
      w_ovf = !w_full_fit;
    end
`ifdef COLUMN_ALU_SAT_EN
    if (w_ovf) w_res = w_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out          <= '0;
      out_ovf      <= 1'b0;
      out_err      <= 1'b0;
      r_acc        <= '0;
      r_sum_active <= 1'b0;
    end else if (w_adv) begin
      out_valid <= w_emit;
      if (w_emit) begin
        out     <= w_res;
        out_ovf <= w_ovf;
        out_err <= w_s2_err;
      end
      if (r_s2_vld && w_is_sum) begin
        r_acc        <= r_s2_last ? '0 : w_acc_sum;
        r_sum_active <= !r_s2_last;
      end
    end
  end
endmodule

// File: tb/tb_column_alu.sv
// Bench for column_alu at WIDTH=8: directed plan items plus randomized traffic against an arithmetic reference model.
module tb_column_alu;
  localparam int W    = 8;
  localparam int ACCW = W + 16;
  localparam longint MAXV = 127;
  localparam longint MINV = -128;
`ifdef COLUMN_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk, reset, enable, in_valid, in_ready, in_last;
  logic         out_valid, out_ready, out_ovf, out_err;
  logic [W-1:0] in1, in2, out;
  logic [3:0]   cmd;

  column_alu #(.WIDTH(W), .CMD_W(4), .ACC_W(ACCW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .cmd(cmd), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_ovf(out_ovf), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int res;
    bit ovf;
    bit err;
  } beat_t;

  beat_t  expq[$];
  beat_t  got_q[$];
  beat_t  mod_q[$];
  longint macc;
  int     nchk = 0;
  int     nerr = 0;
  bit     rnd_on;

  function automatic void chk(string nm, longint act, longint req);
    nchk++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endfunction

  function automatic longint wrapn(longint v, int n);
    longint m;
    m = v & ((longint'(1) << n) - 1);
    if (m >= (longint'(1) << (n - 1))) m = m - (longint'(1) << n);
    return m;
  endfunction

  // Reference: what a beat must produce, from plain integer arithmetic.
  function automatic void model_beat(input int a, input int b, input int c, input bit l,
                                     output bit emit, output beat_t e);
    longint t;
    bit     arith;
    emit = 1'b1; arith = 1'b0; t = 0; e.err = 1'b0; e.ovf = 1'b0;
    case (c)
      0: t = a;
      1: begin t = longint'(a) + b; arith = 1'b1; end
      2: begin t = longint'(a) - b; arith = 1'b1; end
      3: begin t = longint'(a) * b; arith = 1'b1; end
      4: t = (a < b) ? a : b;
      5: t = (a > b) ? a : b;
      6: t = (a == b) ? 1 : 0;
      7: t = (a > b) ? 1 : 0;
      8: begin
        macc  = wrapn(macc + a, ACCW);
        t     = macc;
        arith = 1'b1;
        emit  = l;
        if (l) macc = 0;
      end
      default: begin t = 0; e.err = 1'b1; end
    endcase
    e.ovf = arith && (t > MAXV || t < MINV);
    e.res = int'(wrapn(t, W));
    if (SAT && e.ovf) e.res = (t > MAXV) ? int'(MAXV) : int'(MINV);
  endfunction

  // Every cycle: any presented result must match the head of the expected stream.
  always @(negedge clk) begin
    bit    em;
    beat_t e;
    if (reset) begin
      expq.delete();
      macc = 0;
    end else begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_out actual=%0d required=no beat", $signed(out));
        end else begin
          chk("out", longint'($signed(out)), expq[0].res);
          chk("out_ovf", out_ovf, expq[0].ovf);
          chk("out_err", out_err, expq[0].err);
          if (out_ready) begin
            e.res = int'($signed(out)); e.ovf = out_ovf; e.err = out_err;
            got_q.push_back(e);
            mod_q.push_back(expq[0]);
            void'(expq.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        model_beat(int'($signed(in1)), int'($signed(in2)), int'(cmd), in_last, em, e);
        if (em) expq.push_back(e);
      end
    end
  end

  function automatic void lit(string nm, int idx, int r, bit o, bit er);
    if (idx >= got_q.size()) begin
      nchk++; nerr++;
      $display("FAIL %s actual=missing beat %0d required=%0d", nm, idx, r);
    end else begin
      chk({nm, "_out"}, got_q[idx].res, r);
      chk({nm, "_ovf"}, got_q[idx].ovf, o);
      chk({nm, "_err"}, got_q[idx].err, er);
      chk({nm, "_model"}, mod_q[idx].res, r);
    end
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic send(input int a, input int b, input int c, input bit l);
    int n;
    n = 0;
    in1 = W'(a); in2 = W'(b); cmd = 4'(c); in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      nchk++; nerr++;
      $display("FAIL send_timeout actual=in_ready low required=accept within 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, expq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=still running required=finished");
    $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    in1 = '0; in2 = '0; cmd = '0; out_ready = 1'b1; macc = 0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready", in_ready, 1);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Latency and the ADD overflow boundary
    send(100, 27, 1, 0);
    @(negedge clk); chk("lat_edge_n", out_valid, 0);
    @(negedge clk); chk("lat_edge_n1", out_valid, 0);
    @(negedge clk); chk("lat_edge_n2", out_valid, 1);
    @(posedge clk); #1;
    send(100, 28, 1, 0);
    send(5, 9, 2, 0);
    send(-8, 16, 3, 0);
    send(-3, 4, 4, 0);
    send(7, 7, 7, 0);
    send(50, 0, 8, 0);
    send(50, 0, 8, 0);
    send(50, 0, 8, 1);
    send(3, 0, 8, 1);
    send(55, 1, 12, 0);
    wait_drain("drain_directed");
    lit("add_127", 0, 127, 0, 0);
    lit("add_ovf", 1, SAT ? 127 : -128, 1, 0);
    lit("sub", 2, -4, 0, 0);
    lit("mul", 3, -128, 0, 0);
    lit("min", 4, -3, 0, 0);
    lit("gt_equal", 5, 0, 0, 0);
    lit("sum_150", 6, SAT ? 127 : -106, 1, 0);
    lit("sum_single", 7, 3, 0, 0);
    lit("illegal_op", 8, 0, 0, 1);
    chk("directed_beat_count", got_q.size(), 9);

    // Five-cycle downstream stall in the middle of an ADD stream
    fork
      begin
        for (int i = 0; i < 12; i++) send(rnd8(), rnd8(), 1, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_stall");

    // enable dropped with two beats in flight
    send(3, 4, 1, 0);
    send(5, 6, 2, 0);
    enable = 1'b0;
    in_valid = 1'b1; in1 = 8'd9; cmd = 4'd1;
    repeat (6) begin
      @(negedge clk);
      chk("enable_low_in_ready", in_ready, 0);
    end
    chk("enable_drained", expq.size(), 0);
    @(posedge clk); #1;
    in_valid = 1'b0; enable = 1'b1;

    // Randomized traffic with random backpressure and enable
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int c;
          c = int'($urandom_range(0, 15));
          if ($urandom_range(0, 3) == 0) c = 8;
          send(rnd8(), rnd8(), c, $urandom_range(0, 2) == 0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
          enable    = ($urandom_range(0, 7) != 0);
        end
      end
    join
    out_ready = 1'b1; enable = 1'b1;
    wait_drain("drain_random");

    // Asynchronous reset with a partial SUM (acc=40) and a held result
    @(posedge clk); #1;
    send(0, 0, 8, 1);
    wait_drain("drain_close_sum");
    got_q.delete(); mod_q.delete();
    send(20, 0, 8, 0);
    send(20, 0, 8, 0);
    out_ready = 1'b0;
    send(1, 1, 1, 0);
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1 chk("async_reset_valid", out_valid, 0);
    chk("async_reset_out", out, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    send(1, 0, 8, 1);
    wait_drain("drain_after_reset");
    lit("sum_after_reset", 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
